// File: rtl/byte_loader.sv
// byte_loader: serial-to-parallel front end for the byte memory stage.
// Collects a framed stream of qualified bits into a byte, then holds `store`
// high for STORE_CYCLES cycles with the byte stable on `data`.
// Optional feature: define BYTE_LOADER_PARITY_EN to add an even-parity bit
// after the 8 data bits; a parity failure sets the sticky `frame_err`.
module byte_loader #(
    parameter bit          LSB_FIRST    = 1'b1,
    parameter int unsigned STORE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] data,
    output logic       store,
    output logic       busy,
    output logic       frame_err,
    output logic [7:0] byte_count
);

`ifdef BYTE_LOADER_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity, StStore} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift, StStore} state_e;
`endif

    // Last value of the STORE cycle counter before returning to idle.
    localparam logic [3:0] StoreLast = 4'(STORE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] shift_in;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] store_cnt_q, store_cnt_d;
    logic [7:0] data_q, data_d;
    logic       store_q, store_d;
    logic [7:0] byte_count_q, byte_count_d;
`ifdef BYTE_LOADER_PARITY_EN
    logic       frame_err_q, frame_err_d;
`endif

    // Shift register value with the current bit inserted; the first bit
    // received ends up in data[0] (LSB first) or data[7] (MSB first).
    assign shift_in = LSB_FIRST ? {bit_in, shift_q[7:1]} : {shift_q[6:0], bit_in};

    // Next-state and datapath updates.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        store_cnt_d  = store_cnt_q;
        data_d       = data_q;
        store_d      = store_q;
        byte_count_d = byte_count_q;
`ifdef BYTE_LOADER_PARITY_EN
        frame_err_d  = frame_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                // A bit_valid coinciding with start is deliberately dropped.
                if (start) begin
                    state_d   = StShift;
                    shift_d   = '0;
                    bit_cnt_d = '0;
`ifdef BYTE_LOADER_PARITY_EN
                    frame_err_d = 1'b0;
`endif
                end
            end
            StShift: begin
                if (start) begin
                    // Abort: restart the frame, outputs untouched.
                    shift_d   = '0;
                    bit_cnt_d = '0;
                end else if (bit_valid) begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
`ifdef BYTE_LOADER_PARITY_EN
                        state_d = StParity;
`else
                        state_d      = StStore;
                        data_d       = shift_in;
                        store_d      = 1'b1;
                        byte_count_d = byte_count_q + 8'd1;
                        store_cnt_d  = '0;
                        bit_cnt_d    = '0;
`endif
                    end
                end
            end
`ifdef BYTE_LOADER_PARITY_EN
            StParity: begin
                if (start) begin
                    state_d   = StShift;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                end else if (bit_valid) begin
                    // Even parity: parity bit must equal XOR of the data bits.
                    if ((^shift_q) == bit_in) begin
                        state_d      = StStore;
                        data_d       = shift_q;
                        store_d      = 1'b1;
                        byte_count_d = byte_count_q + 8'd1;
                        store_cnt_d  = '0;
                        bit_cnt_d    = '0;
                    end else begin
                        state_d     = StIdle;
                        frame_err_d = 1'b1;
                    end
                end
            end
`endif
            StStore: begin
                if (store_cnt_q == StoreLast) begin
                    state_d = StIdle;
                    store_d = 1'b0;
                end else begin
                    store_cnt_d = store_cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            store_cnt_q  <= '0;
            data_q       <= '0;
            store_q      <= 1'b0;
            byte_count_q <= '0;
`ifdef BYTE_LOADER_PARITY_EN
            frame_err_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            store_cnt_q  <= store_cnt_d;
            data_q       <= data_d;
            store_q      <= store_d;
            byte_count_q <= byte_count_d;
`ifdef BYTE_LOADER_PARITY_EN
            frame_err_q  <= frame_err_d;
`endif
        end
    end

    assign data       = data_q;
    assign store      = store_q;
    assign busy       = (state_q != StIdle);
    assign byte_count = byte_count_q;
`ifdef BYTE_LOADER_PARITY_EN
    assign frame_err  = frame_err_q;
`else
    assign frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_byte_loader.sv
// Testbench for byte_loader: two instances (LSB-first/2 store cycles and
// MSB-first/3 store cycles) share one randomized stimulus stream; expected
// bytes, counts and strobe lengths come from a frame-level model.
module tb_byte_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, bit_in, bit_valid;
    logic [7:0] data0, data1, cnt0, cnt1;
    logic       store0, store1, busy0, busy1, ferr0, ferr1;

    int         n_checks = 0;
    int         n_fail   = 0;

    // Frame-level model state.
    logic [7:0] exp0, exp1, exp_count;

    always #5 clk = ~clk;

    byte_loader #(.LSB_FIRST(1'b1), .STORE_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .data(data0), .store(store0), .busy(busy0), .frame_err(ferr0), .byte_count(cnt0)
    );

    byte_loader #(.LSB_FIRST(1'b0), .STORE_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .data(data1), .store(store1), .busy(busy1), .frame_err(ferr1), .byte_count(cnt1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy0 || busy1) && n < 50) begin
            tick();
            n++;
        end
        if (busy0 || busy1) check_eq("idle_timeout", 32'(busy0 | busy1), 0);
    endtask

    // gap < 0 picks a random gap of 0..2 idle cycles before the bit.
    task automatic send_bit(input logic v, input int gap);
        int g;
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        for (int i = 0; i < g; i++) begin
            bit_valid = 1'b0;
            bit_in    = 1'($urandom);
            tick();
        end
        bit_valid = 1'b1;
        bit_in    = v;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input int gap, input int abort_at,
                              input bit bad_par, input bit rst_in_store);
        int k0, k1;
        bit early;
        wait_idle();
        // start with a simultaneous bit_valid=1 that must be ignored
        start     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        start     = 1'b0;
        bit_valid = 1'b0;
        check_eq("busy_after_start0", 32'(busy0), 1);
        check_eq("busy_after_start1", 32'(busy1), 1);
        check_eq("ferr_after_start", 32'(ferr0 | ferr1), 0);
        if (abort_at > 0) begin
            for (int i = 0; i < abort_at; i++) send_bit(1'($urandom), gap);
            start     = 1'b1;
            bit_valid = 1'b1;
            bit_in    = 1'($urandom);
            tick();
            start     = 1'b0;
            bit_valid = 1'b0;
            check_eq("abort_no_store", 32'(store0 | store1), 0);
            check_eq("abort_data0", 32'(data0), 32'(exp0));
            check_eq("abort_busy", 32'(busy0 & busy1), 1);
        end
        early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_bit(b[i], gap);
            if (i < 7 && (store0 || store1)) early = 1'b1;
        end
        check_eq("early_store", 32'(early), 0);
`ifdef BYTE_LOADER_PARITY_EN
        check_eq("no_store_before_par", 32'(store0 | store1), 0);
        send_bit(bad_par ? ~(^b) : ^b, gap);
`endif
        if (!bad_par) begin
            exp_count = exp_count + 8'd1;
            exp0      = b;
            exp1      = rev8(b);
            check_eq("store_rise0", 32'(store0), 1);
            check_eq("store_rise1", 32'(store1), 1);
            check_eq("data0", 32'(data0), 32'(exp0));
            check_eq("data1", 32'(data1), 32'(exp1));
            check_eq("count0", 32'(cnt0), 32'(exp_count));
            check_eq("count1", 32'(cnt1), 32'(exp_count));
            check_eq("ferr_ok", 32'(ferr0 | ferr1), 0);
            if (rst_in_store) begin
                #2 rst_n = 1'b0;
                #1;
                check_eq("rst_store", 32'(store0 | store1), 0);
                check_eq("rst_data0", 32'(data0), 0);
                check_eq("rst_data1", 32'(data1), 0);
                check_eq("rst_count", 32'(cnt0 | cnt1), 0);
                check_eq("rst_busy", 32'(busy0 | busy1), 0);
                tick();
                rst_n     = 1'b1;
                exp_count = 8'd0;
                exp0      = 8'd0;
                exp1      = 8'd0;
                return;
            end
            k0 = 0;
            k1 = 0;
            for (int k = 1; k <= 8 && (k0 == 0 || k1 == 0); k++) begin
                // noise during STORE: start only while both are still storing
                start     = (k == 1) ? 1'($urandom) : 1'b0;
                bit_valid = 1'($urandom);
                bit_in    = 1'($urandom);
                tick();
                if (store0) check_eq("hold_data0", 32'(data0), 32'(exp0));
                if (store1) check_eq("hold_data1", 32'(data1), 32'(exp1));
                if (k0 == 0 && !store0) begin
                    k0 = k;
                    check_eq("busy_fall0", 32'(busy0), 0);
                end
                if (k1 == 0 && !store1) begin
                    k1 = k;
                    check_eq("busy_fall1", 32'(busy1), 0);
                end
            end
            start     = 1'b0;
            bit_valid = 1'b0;
            check_eq("store_len0", 32'(k0), 2);
            check_eq("store_len1", 32'(k1), 3);
            check_eq("count_after0", 32'(cnt0), 32'(exp_count));
        end else begin
            check_eq("perr_flag0", 32'(ferr0), 1);
            check_eq("perr_flag1", 32'(ferr1), 1);
            check_eq("perr_no_store", 32'(store0 | store1), 0);
            check_eq("perr_idle", 32'(busy0 | busy1), 0);
            check_eq("perr_data0", 32'(data0), 32'(exp0));
            check_eq("perr_data1", 32'(data1), 32'(exp1));
            check_eq("perr_count", 32'(cnt0), 32'(exp_count));
            tick();
            check_eq("perr_sticky", 32'(ferr0), 1);
        end
    endtask

    initial begin
        bit par_bad;
        int ab;
        rst_n     = 1'b0;
        start     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        exp0      = 8'd0;
        exp1      = 8'd0;
        exp_count = 8'd0;
        tick();
        tick();
        check_eq("reset_data", 32'(data0 | data1), 0);
        check_eq("reset_store", 32'(store0 | store1), 0);
        check_eq("reset_busy", 32'(busy0 | busy1), 0);
        check_eq("reset_ferr", 32'(ferr0 | ferr1), 0);
        check_eq("reset_count", 32'(cnt0 | cnt1), 0);
        rst_n = 1'b1;
        tick();

        // bits 1,0,1,1,0,0,1,0 -> 8'h4D LSB-first, 8'hB2 MSB-first
        send_frame(8'h4D, 0, 0, 1'b0, 1'b0);
        send_frame(8'h4D, 3, 0, 1'b0, 1'b0);
        send_frame(8'hFF, 0, 5, 1'b0, 1'b0);
        send_frame(8'hA5, 0, 0, 1'b0, 1'b1);
        send_frame(8'h3C, 1, 0, 1'b0, 1'b0);
        send_frame(8'h01, 0, 0, 1'b0, 1'b0);
`ifdef BYTE_LOADER_PARITY_EN
        send_frame(8'h4D, 0, 0, 1'b0, 1'b0);
        send_frame(8'h4D, 0, 0, 1'b1, 1'b0);
        send_frame(8'h4D, 0, 0, 1'b0, 1'b0);
`endif

        for (int f = 0; f < 280; f++) begin
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
`ifdef BYTE_LOADER_PARITY_EN
            par_bad = ($urandom_range(0, 5) == 0);
`else
            par_bad = 1'b0;
`endif
            send_frame(8'($urandom), -1, ab, par_bad, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
